// File: rtl/boot_pkg.sv
// boot_pkg: shared state encoding and stream framing constants for the boot loader.
package boot_pkg;
    typedef enum logic [2:0] {LEN_LO, LEN_HI, WORD, WRITE, DONE, ERROR} boot_state_e;
    localparam int BOOT_LEN_BYTES  = 2;
    localparam int BOOT_WORD_BYTES = 4;
endpackage

// File: rtl/boot_word_packer.sv
// boot_word_packer: MSB-first byte-to-word shift register with byte counter.
// Ports: clk, rst (async active-low), clr_i (restart count), shift_i (accept byte_i),
//        byte_i (incoming byte), word_o (word completed by byte_i), word_full_o (byte_i is the last byte).
module boot_word_packer
    import boot_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         shift_i,
    input  logic [7:0]                   byte_i,
    output logic [BOOT_WORD_BYTES*8-1:0] word_o,
    output logic                         word_full_o
);
    localparam int SW = (BOOT_WORD_BYTES - 1) * 8;
    localparam int CW = $clog2(BOOT_WORD_BYTES);
    logic [SW-1:0] sr_q;
    logic [CW-1:0] cnt_q;
    // Only the earlier bytes are stored; the final byte is merged combinationally
    // so the word is ready on the same edge that accepts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (shift_i) begin
            sr_q  <= {sr_q[SW-9:0], byte_i};
            cnt_q <= cnt_q + CW'(1);
        end
    end
    assign word_o      = {sr_q, byte_i};
    assign word_full_o = (cnt_q == CW'(BOOT_WORD_BYTES - 1));
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a length-prefixed byte stream into instruction memory, then releases the core.
// Ports: clk, rst (async active-low); byte_valid/byte_data/byte_ready host byte handshake;
//        reload restarts from DONE/ERROR; imem_we/imem_addr/imem_wdata memory write port;
//        cpu_rst core reset; load_done/load_error status; words_loaded progress count.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam int LW = BOOT_LEN_BYTES * 8;
    boot_state_e           state_q;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         len_d;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH:0]   words_loaded_q;
    logic                  byte_ready_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  cpu_rst_q;
    logic                  load_done_q;
    logic                  load_error_q;
    logic                  xfer;
    logic                  last_word;
    logic                  too_long;
    logic [31:0]           word_d;
    logic                  word_full;
    assign xfer      = byte_valid & byte_ready_q;
    assign len_d     = {byte_data, len_q[7:0]};
    assign too_long  = 32'(len_d) > 32'(MAX_WORDS);
    assign last_word = (LW'(idx_q) == len_q - LW'(1));
    boot_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q != WORD),
        .shift_i    (xfer && state_q == WORD),
        .byte_i     (byte_data),
        .word_o     (word_d),
        .word_full_o(word_full)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= LEN_LO;
            len_q          <= '0;
            idx_q          <= '0;
            words_loaded_q <= '0;
            byte_ready_q   <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            cpu_rst_q      <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                LEN_LO: begin
                    // Raises ready on the first edge after reset release.
                    byte_ready_q <= 1'b1;
                    if (xfer) begin
                        len_q[7:0] <= byte_data;
                        state_q    <= LEN_HI;
                    end
                end
                LEN_HI: if (xfer) begin
                    len_q <= len_d;
                    if (len_d == '0) begin
                        state_q      <= DONE;
                        byte_ready_q <= 1'b0;
                        load_done_q  <= 1'b1;
                        cpu_rst_q    <= 1'b0;
                    end else if (too_long) begin
                        state_q      <= ERROR;
                        byte_ready_q <= 1'b0;
                        load_error_q <= 1'b1;
                    end else begin
                        state_q <= WORD;
                    end
                end
                WORD: if (xfer && word_full) begin
                    state_q      <= WRITE;
                    byte_ready_q <= 1'b0;
                    imem_we_q    <= 1'b1;
                    imem_addr_q  <= idx_q;
                    imem_wdata_q <= word_d;
                end
                WRITE: begin
                    words_loaded_q <= words_loaded_q + 1'b1;
                    if (last_word) begin
                        state_q     <= DONE;
                        load_done_q <= 1'b1;
                        cpu_rst_q   <= 1'b0;
                    end else begin
                        state_q      <= WORD;
                        idx_q        <= idx_q + 1'b1;
                        byte_ready_q <= 1'b1;
                    end
                end
                DONE, ERROR: if (reload) begin
                    state_q        <= LEN_LO;
                    idx_q          <= '0;
                    words_loaded_q <= '0;
                    byte_ready_q   <= 1'b1;
                    cpu_rst_q      <= 1'b1;
                    load_done_q    <= 1'b0;
                    load_error_q   <= 1'b0;
                end
                default: state_q <= LEN_LO;
            endcase
        end
    end
    assign byte_ready   = byte_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;
    assign words_loaded = words_loaded_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed self-checking bench for imem_boot_loader.
module tb_imem_boot_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_error;
    logic [8:0]  words_loaded;
    int          ncmp = 0;
    int          nerr = 0;
    int          wr_count = 0;
    int          wc0;
    int          rdy_seen;
    logic [31:0] mem [256];
    logic [31:0] w;

    imem_boot_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .reload      (reload),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_rst     (cpu_rst),
        .load_done   (load_done),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        @(negedge clk);
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] wd, input int maxgap);
        for (int k = 0; k < 4; k++) send_byte(wd[31-8*k -: 8], int'($urandom_range(0, maxgap)));
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_done", load_done, 0);
        chk("rst_error", load_error, 0);
        chk("rst_words", words_loaded, 0);
        rst = 1'b1;
        #1;
        chk("ready_before_edge", byte_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", byte_ready, 1);

        // Test 1: two-word image
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_word(32'h20080005, 0);
        chk("t1_we0", imem_we, 1);
        chk("t1_addr0", imem_addr, 0);
        chk("t1_wdata0", imem_wdata, 32'h20080005);
        chk("t1_ready_in_write", byte_ready, 0);
        chk("t1_words_in_write", words_loaded, 0);
        send_word(32'h20090000, 0);
        chk("t1_we1", imem_we, 1);
        chk("t1_addr1", imem_addr, 1);
        chk("t1_wdata1", imem_wdata, 32'h20090000);
        chk("t1_cpu_rst_in_write", cpu_rst, 1);
        @(posedge clk);
        #1;
        chk("t1_cpu_rst_fall", cpu_rst, 0);
        chk("t1_done", load_done, 1);
        chk("t1_we_low", imem_we, 0);
        chk("t1_addr_hold", imem_addr, 1);
        chk("t1_words", words_loaded, 2);
        chk("t1_mem0", mem[0], 32'h20080005);
        chk("t1_mem1", mem[1], 32'h20090000);
        chk("t1_wr_count", wr_count, 2);
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        rdy_seen   = 0;
        repeat (3) begin
            @(negedge clk);
            if (byte_ready) rdy_seen++;
        end
        byte_valid = 1'b0;
        chk("t1_no_accept_after_done", rdy_seen, 0);
        chk("t1_still_done", load_done, 1);

        // Test 2: empty image
        pulse_reload();
        chk("t2_reload_done_clr", load_done, 0);
        chk("t2_reload_cpu_rst", cpu_rst, 1);
        chk("t2_reload_ready", byte_ready, 1);
        wc0 = wr_count;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("t2_done", load_done, 1);
        chk("t2_cpu_rst", cpu_rst, 0);
        chk("t2_ready", byte_ready, 0);
        chk("t2_words", words_loaded, 0);
        chk("t2_no_write", wr_count - wc0, 0);

        // Test 3: over-length image
        pulse_reload();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("t3_error", load_error, 1);
        chk("t3_cpu_rst", cpu_rst, 1);
        chk("t3_ready", byte_ready, 0);
        chk("t3_done", load_done, 0);
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        rdy_seen   = 0;
        repeat (4) begin
            @(negedge clk);
            if (byte_ready) rdy_seen++;
        end
        byte_valid = 1'b0;
        chk("t3_no_accept", rdy_seen, 0);
        chk("t3_error_held", load_error, 1);
        @(posedge clk);
        #1;
        pulse_reload();
        chk("t3_reload_err_clr", load_error, 0);
        chk("t3_reload_ready", byte_ready, 1);
        chk("t3_reload_cpu_rst", cpu_rst, 1);

        // Test 5: reset during word 1 of a 3-word load, then resend
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_word(32'h11111111, 0);
        send_byte(8'h22, 0);
        send_byte(8'h22, 0);
        chk("t5_words_before", words_loaded, 1);
        rst = 1'b0;
        #1;
        chk("t5_async_cpu_rst", cpu_rst, 1);
        chk("t5_async_words", words_loaded, 0);
        chk("t5_async_ready", byte_ready, 0);
        chk("t5_async_addr", imem_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        send_word(32'h11223344, 0);
        send_word(32'h55667788, 0);
        send_word(32'h99AABBCC, 0);
        @(posedge clk);
        #1;
        chk("t5_done", load_done, 1);
        chk("t5_words", words_loaded, 3);
        chk("t5_mem0", mem[0], 32'h11223344);
        chk("t5_mem1", mem[1], 32'h55667788);
        chk("t5_mem2", mem[2], 32'h99AABBCC);

        // Test 6: reload from DONE with a one-word image
        pulse_reload();
        chk("t6_cpu_rst_reload", cpu_rst, 1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hA0, 0);
        chk("t6_cpu_rst_loading", cpu_rst, 1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("t6_we", imem_we, 1);
        @(posedge clk);
        #1;
        chk("t6_done", load_done, 1);
        chk("t6_cpu_rst", cpu_rst, 0);
        chk("t6_mem0", mem[0], 32'hA0000000);
        chk("t6_words", words_loaded, 1);

        // Test 4: image of test 1 with random valid gaps
        pulse_reload();
        wc0 = wr_count;
        send_byte(8'h02, int'($urandom_range(0, 3)));
        send_byte(8'h00, int'($urandom_range(0, 3)));
        send_word(32'h20080005, 3);
        send_word(32'h20090000, 3);
        @(posedge clk);
        #1;
        chk("t4_done", load_done, 1);
        chk("t4_mem0", mem[0], 32'h20080005);
        chk("t4_mem1", mem[1], 32'h20090000);
        chk("t4_writes", wr_count - wc0, 2);
        chk("t4_words", words_loaded, 2);

        // Boundary: N == MAX_WORDS fills addresses 0..255
        pulse_reload();
        wc0 = wr_count;
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        chk("tmax_not_error", load_error, 0);
        for (int i = 0; i < 256; i++) begin
            w = {8'hC0, 8'(i), 8'h5A, ~8'(i)};
            send_word(w, 0);
        end
        @(posedge clk);
        #1;
        chk("tmax_done", load_done, 1);
        chk("tmax_words", words_loaded, 9'h100);
        chk("tmax_addr", imem_addr, 8'hFF);
        chk("tmax_writes", wr_count - wc0, 256);
        chk("tmax_mem0", mem[0], 32'hC0005AFF);
        chk("tmax_mem128", mem[128], 32'hC0805A7F);
        chk("tmax_mem255", mem[255], 32'hC0FF5A00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
